// File: rtl/vic_bankcart_if.sv
// vic_bankcart_if: bus bundle between VIC decode, the cartridge mapper,
// SDRAM and the NVRAM save controller. The master side is the VIC/system
// side that drives the CPU bus. The slave side is the mapper.
interface vic_bankcart_if #(
   parameter int ADDR_W = 23
);
   logic              active;
   logic [15:0]       vic_addr;
   logic              vic_wr_n;
   logic [3:0]        vic_win_sel;
   logic              vic_ram123_sel;
   logic              vic_io2_sel;
   logic              vic_io3_sel;
   logic [7:0]        from_vic;
   logic [7:0]        to_vic;
   logic              mc_qm;
   logic [ADDR_W-1:0] mc_addr;
   logic              mc_wr_n;
   logic              mc_rom_sel;
   logic              mc_ram_sel;
   logic              mc_nvram_sel;
   logic              mc_soft_reset;
   logic              nv_save_req;
   logic              nv_save_ack;

   modport master (
      output active, vic_addr, vic_wr_n, vic_win_sel, vic_ram123_sel,
             vic_io2_sel, vic_io3_sel, from_vic, nv_save_ack,
      input  to_vic, mc_qm, mc_addr, mc_wr_n, mc_rom_sel, mc_ram_sel,
             mc_nvram_sel, mc_soft_reset, nv_save_req
   );

   modport slave (
      input  active, vic_addr, vic_wr_n, vic_win_sel, vic_ram123_sel,
             vic_io2_sel, vic_io3_sel, from_vic, nv_save_ack,
      output to_vic, mc_qm, mc_addr, mc_wr_n, mc_rom_sel, mc_ram_sel,
             mc_nvram_sel, mc_soft_reset, nv_save_req
   );
endinterface

// File: rtl/vic_bankcart.sv
// vic_bankcart: four-window banked cartridge mapper for the VIC-20 core.
// BLK1/2/3/5 each map an 8K ROM or cart RAM bank in SDRAM. Bank and control
// registers live in IO3. A counted soft-reset sequencer leaves boot mode.
// Optional feature: define VIC_BANKCART_AUTOSAVE_EN to build the NVRAM
// autosave dirty tracker. Without it nv_save_req is tied low.
module vic_bankcart #(
   parameter int ROM_BANK_BITS = 8,
   parameter int RAM_BANK_BITS = 2,
   parameter int ADDR_W        = 23,
   parameter int RESET_CYCLES  = 16,
   parameter int SAVE_IDLE     = 2000000
) (
   input logic           clk,
   input logic           reset_n,
   vic_bankcart_if.slave bus
);

   // bank_hi keeps ram_en, wr_en and only the upper ROM bank bits that exist
   localparam int         HI_BITS = (ROM_BANK_BITS > 8) ? (ROM_BANK_BITS - 8) : 0;
   localparam logic [7:0] HI_MASK = 8'hC0 | 8'((1 << HI_BITS) - 1);
   localparam int         CNT_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

   logic [7:0]         bank_lo [4];
   logic [7:0]         bank_hi [4];
   logic               nvram_en;
   logic               lock;
   logic               boot;
   state_t             state;
   logic [CNT_W-1:0]   count;
   logic               soft_reset;
   logic               active_prev;
   logic [7:0]         to_vic_q;
   logic               qm_q;

   logic [7:0]         reg_off;
   logic               reg_wr;
   logic               reg_rd;
   logic               bank_reg;
   logic               ctrl_reg;
   logic               reset_reg;
   logic               rd_valid;
   logic [7:0]         rd_data;
   logic               trigger;

   logic               win_hit;
   logic [1:0]         win_idx;
   logic [7:0]         sel_lo;
   logic [7:0]         sel_hi;
   logic [ROM_BANK_BITS-1:0] rom_bank;
   logic [RAM_BANK_BITS-1:0] ram_bank;
   logic               map_rom;
   logic               map_ram;
   logic               map_nvram;
   logic               map_wr_n;
   logic [ADDR_W-1:0]  map_addr;

   assign reg_off   = bus.vic_addr[7:0];
   assign reg_wr    = bus.vic_io3_sel & ~bus.vic_wr_n;
   assign reg_rd    = bus.vic_io3_sel & bus.vic_wr_n;
   assign bank_reg  = (reg_off[7:3] == 5'd0);
   assign ctrl_reg  = (reg_off == 8'h80);
   assign reset_reg = (reg_off == 8'h81);
   assign rd_valid  = reg_rd & (bank_reg | ctrl_reg);
   assign trigger   = (reg_wr & reset_reg) | (bus.active & ~active_prev);

   // Register read mux; unused bits are already zero in storage
   always_comb begin
      rd_data = 8'h00;
      if (bank_reg) begin
         rd_data = reg_off[0] ? bank_hi[reg_off[2:1]] : bank_lo[reg_off[2:1]];
      end else if (ctrl_reg) begin
         rd_data = {6'b0, lock, nvram_en};
      end
   end

   // Pick the selected window, lowest index wins if several are asserted
   always_comb begin
      win_hit = 1'b0;
      win_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.vic_win_sel[i]) begin
            win_hit = 1'b1;
            win_idx = 2'(i);
         end
      end
   end

   // Same-cycle address mapping and write filtering towards SDRAM
   always_comb begin
      sel_lo    = bank_lo[win_idx];
      sel_hi    = bank_hi[win_idx];
      rom_bank  = boot ? '1 : ROM_BANK_BITS'({sel_hi[5:0], sel_lo});
      ram_bank  = sel_lo[RAM_BANK_BITS-1:0];
      map_rom   = 1'b0;
      map_ram   = 1'b0;
      map_nvram = 1'b0;
      map_addr  = '0;
      map_wr_n  = bus.vic_wr_n;
      if (bus.active) begin
         if (win_hit) begin
            if (sel_hi[7] && !boot) begin
               map_ram  = 1'b1;
               map_addr = ADDR_W'({ram_bank, bus.vic_addr[12:0]});
               map_wr_n = bus.vic_wr_n | ~sel_hi[6];
            end else begin
               map_rom  = 1'b1;
               map_addr = ADDR_W'({rom_bank, bus.vic_addr[12:0]});
               map_wr_n = 1'b1;
            end
         end else if (nvram_en &&
                      (bus.vic_ram123_sel || bus.vic_io2_sel || bus.vic_io3_sel)) begin
            map_nvram = 1'b1;
            map_addr  = ADDR_W'(bus.vic_addr);
         end
      end
   end

   // Bank/control register writes and the registered read port
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            bank_lo[i] <= 8'h00;
            bank_hi[i] <= 8'h00;
         end
         nvram_en <= 1'b0;
         lock     <= 1'b0;
         to_vic_q <= 8'h00;
         qm_q     <= 1'b0;
      end else begin
         if (reg_wr && bank_reg && !lock) begin
            if (reg_off[0]) begin
               bank_hi[reg_off[2:1]] <= bus.from_vic & HI_MASK;
            end else begin
               bank_lo[reg_off[2:1]] <= bus.from_vic;
            end
         end
         if (reg_wr && ctrl_reg) begin
            nvram_en <= bus.from_vic[0];
            lock     <= lock | bus.from_vic[1];
         end
         qm_q     <= rd_valid;
         to_vic_q <= rd_valid ? rd_data : 8'h00;
      end
   end

   // Soft-reset sequencer: hold the CPU in reset, then leave boot mode
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         soft_reset  <= 1'b0;
         boot        <= 1'b1;
         active_prev <= bus.active;
      end else begin
         active_prev <= bus.active;
         case (state)
            IDLE: begin
               if (trigger) begin
                  state      <= HOLD;
                  count      <= CNT_W'(RESET_CYCLES - 1);
                  soft_reset <= 1'b1;
               end
            end
            HOLD: begin
               if (count == '0) begin
                  state      <= DONE;
                  soft_reset <= 1'b0;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE: begin
               boot  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               soft_reset <= 1'b0;
            end
         endcase
      end
   end

`ifdef VIC_BANKCART_AUTOSAVE_EN
   localparam int IDLE_W = $clog2(SAVE_IDLE + 1);

   logic              nv_write;
   logic              dirty;
   logic              save_req;
   logic [IDLE_W-1:0] idle_cnt;

   assign nv_write = map_nvram & ~bus.vic_wr_n;

   // Track unsaved NVRAM writes and request a save once the bus stays quiet
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dirty    <= 1'b0;
         save_req <= 1'b0;
         idle_cnt <= '0;
      end else if (save_req && bus.nv_save_ack) begin
         save_req <= 1'b0;
         dirty    <= nv_write;
         if (nv_write) begin
            idle_cnt <= '0;
         end
      end else if (nv_write) begin
         dirty    <= 1'b1;
         idle_cnt <= '0;
      end else if (dirty && !save_req) begin
         idle_cnt <= idle_cnt + 1'b1;
         if (idle_cnt == IDLE_W'(SAVE_IDLE - 1)) begin
            save_req <= 1'b1;
         end
      end
   end

   assign bus.nv_save_req = save_req;
`else
   logic unused_save_ack;

   assign unused_save_ack = bus.nv_save_ack;
   assign bus.nv_save_req = 1'b0;
`endif

   assign bus.mc_addr       = map_addr;
   assign bus.mc_rom_sel    = map_rom;
   assign bus.mc_ram_sel    = map_ram;
   assign bus.mc_nvram_sel  = map_nvram;
   assign bus.mc_wr_n       = map_wr_n;
   assign bus.mc_soft_reset = soft_reset;
   assign bus.to_vic        = to_vic_q;
   assign bus.mc_qm         = qm_q;

endmodule

// File: tb/tb_vic_bankcart.sv
// tb_vic_bankcart: directed scenarios plus randomized bus traffic for
// vic_bankcart, checked against a behavioural model of the mapper.
module tb_vic_bankcart;
   localparam int R = 16;
   localparam int S = 100;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   bit   cur_active = 1'b1;

   always #5 clk = ~clk;

   vic_bankcart_if #(.ADDR_W(23)) bus ();

   vic_bankcart #(
      .ROM_BANK_BITS(8), .RAM_BANK_BITS(2), .ADDR_W(23),
      .RESET_CYCLES(R), .SAVE_IDLE(S)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int check_count = 0;
   int pass_count  = 0;
   int soft_high   = 0;

   logic [7:0] m_lo [4];
   logic [7:0] m_hi [4];
   bit         m_nvram_en, m_lock, m_boot, m_qm, m_active_prev;
   logic [7:0] m_to_vic;
   int         edge_no = 0;
   bit         seq_valid;
   int         seq_start;
   bit         m_dirty, m_req;
   int         m_last_wr;

   logic [22:0] e_addr;
   bit          e_rom, e_ram, e_nv, e_wr_n;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                    tag, actual, expected, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_lo[i] = 8'h00;
         m_hi[i] = 8'h00;
      end
      m_nvram_en = 0; m_lock = 0; m_boot = 1; m_qm = 0; m_to_vic = 8'h00;
      seq_valid = 0; seq_start = 0; m_dirty = 0; m_req = 0; m_last_wr = 0;
   endtask

   // What the mapper should present on the SDRAM side for the current inputs
   task automatic compute_comb();
      int win = -1;
      int a = int'(bus.vic_addr);
      e_addr = '0; e_rom = 0; e_ram = 0; e_nv = 0; e_wr_n = bus.vic_wr_n;
      for (int i = 3; i >= 0; i--) if (bus.vic_win_sel[i]) win = i;
      if (bus.active && win >= 0) begin
         if (!m_boot && m_hi[win][7]) begin
            e_ram  = 1;
            e_addr = 23'((int'(m_lo[win]) % 4) * 8192 + a % 8192);
            e_wr_n = bus.vic_wr_n || !m_hi[win][6];
         end else begin
            e_rom  = 1;
            e_addr = 23'((m_boot ? 255 : int'(m_lo[win])) * 8192 + a % 8192);
            e_wr_n = 1;
         end
      end else if (bus.active && m_nvram_en &&
                   (bus.vic_ram123_sel || bus.vic_io2_sel || bus.vic_io3_sel)) begin
         e_nv   = 1;
         e_addr = 23'(a);
      end
   endtask

   // Advance the model by one clock edge using the inputs held across it
   task automatic model_edge();
      int off = int'(bus.vic_addr[7:0]);
      bit wr  = bus.vic_io3_sel && !bus.vic_wr_n;
      bit rd  = bus.vic_io3_sel && bus.vic_wr_n;
      bit nv_w = e_nv && !bus.vic_wr_n;
      bit trig;
      edge_no++;
      if (!reset_n) begin
         model_reset();
         m_active_prev = bus.active;
         return;
      end
      m_qm = rd && (off < 8 || off == 128);
      if (m_qm) begin
         if (off == 128) m_to_vic = {6'b0, m_lock, m_nvram_en};
         else if (off % 2 == 1) m_to_vic = m_hi[off / 2] & 8'hC0;
         else m_to_vic = m_lo[off / 2];
      end else begin
         m_to_vic = 8'h00;
      end
      trig = (wr && off == 129) || (bus.active && !m_active_prev);
      m_active_prev = bus.active;
      if (seq_valid && edge_no == seq_start + R + 1) m_boot = 0;
      if (trig && !(seq_valid && edge_no <= seq_start + R + 1)) begin
         seq_valid = 1;
         seq_start = edge_no;
      end
      if (wr && off < 8 && !m_lock) begin
         if (off % 2 == 1) m_hi[off / 2] = bus.from_vic;
         else m_lo[off / 2] = bus.from_vic;
      end
      if (wr && off == 128) begin
         m_nvram_en = bus.from_vic[0];
         m_lock     = m_lock | bus.from_vic[1];
      end
`ifdef VIC_BANKCART_AUTOSAVE_EN
      if (m_req && bus.nv_save_ack) begin
         m_req = 0;
         m_dirty = nv_w;
         if (nv_w) m_last_wr = edge_no;
      end else if (nv_w) begin
         m_dirty = 1;
         m_last_wr = edge_no;
      end
      if (m_dirty && !m_req && edge_no - m_last_wr >= S) m_req = 1;
`else
      if (nv_w) m_req = 0;
`endif
   endtask

   task automatic step();
      compute_comb();
      #1;
      if (reset_n) begin
         checkOutput("mc_addr",      bus.mc_addr,      e_addr);
         checkOutput("mc_rom_sel",   bus.mc_rom_sel,   e_rom);
         checkOutput("mc_ram_sel",   bus.mc_ram_sel,   e_ram);
         checkOutput("mc_nvram_sel", bus.mc_nvram_sel, e_nv);
         checkOutput("mc_wr_n",      bus.mc_wr_n,      e_wr_n);
      end
      @(posedge clk);
      model_edge();
      #1;
      checkOutput("mc_soft_reset", bus.mc_soft_reset,
                  seq_valid && (edge_no - seq_start < R));
      checkOutput("mc_qm", bus.mc_qm, m_qm);
      if (m_qm) checkOutput("to_vic", bus.to_vic, m_to_vic);
      checkOutput("nv_save_req", bus.nv_save_req, m_req);
      if (bus.mc_soft_reset === 1'b1) soft_high++;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input bit act, input logic [15:0] addr, input bit wr_n,
                                input logic [3:0] win, input bit r123, input bit io2,
                                input bit io3, input logic [7:0] data, input bit ack);
      bus.active = act; bus.vic_addr = addr; bus.vic_wr_n = wr_n;
      bus.vic_win_sel = win; bus.vic_ram123_sel = r123; bus.vic_io2_sel = io2;
      bus.vic_io3_sel = io3; bus.from_vic = data; bus.nv_save_ack = ack;
      step();
   endtask

   task automatic idle(input int n, input bit ack = 0);
      for (int k = 0; k < n; k++)
         applyStimulus(cur_active, 16'h0000, 1, 4'b0, 0, 0, 0, 8'h00, ack);
   endtask

   task automatic reg_write(input int off, input logic [7:0] d);
      applyStimulus(cur_active, 16'h9C00 | 16'(off), 0, 4'b0, 0, 0, 1, d, 0);
   endtask

   task automatic reg_read(input int off);
      applyStimulus(cur_active, 16'h9C00 | 16'(off), 1, 4'b0, 0, 0, 1, 8'h00, 0);
   endtask

   task automatic win_access(input int w, input int low, input bit wr_n);
      logic [15:0] base;
      case (w)
         0: base = 16'h2000;
         1: base = 16'h4000;
         2: base = 16'h6000;
         default: base = 16'hA000;
      endcase
      applyStimulus(cur_active, base | 16'(low % 8192), wr_n, 4'(1 << w), 0, 0, 0,
                    8'($urandom), 0);
   endtask

   task automatic nv_access(input logic [15:0] addr, input bit wr_n, input bit ack);
      applyStimulus(cur_active, addr, wr_n, 4'b0, addr < 16'h1000, addr >= 16'h9800,
                    0, 8'($urandom), ack);
   endtask

   initial begin
      int n;
      model_reset();
      reset_n = 0;
      idle(3);
      reset_n = 1;

      // boot mapping: every window shows ROM bank 0xFF
      win_access(3, 13'h0123, 1);
      checkOutput("boot_rom_sel", bus.mc_rom_sel, 1);
      checkOutput("boot_addr", bus.mc_addr, 23'h1FE123);

      // bank BLK5 to 5, soft reset leaves boot mode
      reg_write(6, 8'h05);
      reg_write(7, 8'h00);
      soft_high = 0;
      reg_write(8'h81, 8'h00);
      idle(R + 2);
      checkOutput("pulse_len", soft_high, R);
      win_access(3, 13'h0123, 1);
      checkOutput("blk5_addr", bus.mc_addr, 23'h00A123);

      // BLK1 as RAM bank 2, write-protected then writable
      reg_write(0, 8'h02);
      reg_write(1, 8'h80);
      win_access(0, 13'h0010, 0);
      checkOutput("ram_sel", bus.mc_ram_sel, 1);
      checkOutput("ram_wp", bus.mc_wr_n, 1);
      checkOutput("ram_addr", bus.mc_addr, 23'h004010);
      reg_write(1, 8'hC0);
      win_access(0, 13'h0010, 0);
      checkOutput("ram_wr", bus.mc_wr_n, 0);

      // lock blocks bank writes, ctrl readback, bits 9:8 ignored
      reg_write(8'h80, 8'h03);
      reg_write(0, 8'h11);
      reg_read(0);
      checkOutput("locked_lo", bus.to_vic, 8'h02);
      checkOutput("locked_qm", bus.mc_qm, 1);
      reg_read(8'h80);
      checkOutput("ctrl_rd", bus.to_vic, 8'h03);
      reg_write(8'h80, 8'h00);
      reg_read(8'h80);
      checkOutput("lock_sticky", bus.to_vic, 8'h02);
      reg_read(12'h301);
      checkOutput("alias_hi", bus.to_vic, 8'hC0);
      reg_read(8'h08);
      checkOutput("bad_off_qm", bus.mc_qm, 0);

      // reset_n clears lock; active toggle and reset_n mid-HOLD
      reset_n = 0;
      idle(1);
      reset_n = 1;
      reg_read(8'h80);
      checkOutput("ctrl_after_rst", bus.to_vic, 8'h00);
      reg_write(8'h81, 8'h00);
      idle(3);
      cur_active = 0;
      idle(1);
      cur_active = 1;
      idle(1);
      reset_n = 0;
      idle(1);
      checkOutput("rst_mid_hold", bus.mc_soft_reset, 0);
      reset_n = 1;
      soft_high = 0;
      idle(R + 4);
      checkOutput("no_second_pulse", soft_high, 0);

      // trigger during DONE is ignored
      soft_high = 0;
      reg_write(8'h81, 8'h00);
      idle(R);
      reg_write(8'h81, 8'h00);
      idle(R + 4);
      checkOutput("done_trigger", soft_high, R);

      // simultaneous 0x81 write and active edge give one sequence
      cur_active = 0;
      idle(1);
      cur_active = 1;
      soft_high = 0;
      reg_write(8'h81, 8'h00);
      idle(R + 6);
      checkOutput("simul_trigger", soft_high, R);

      reg_write(8'h80, 8'h01);
      nv_access(16'h0400, 0, 0);
`ifdef VIC_BANKCART_AUTOSAVE_EN
      n = 0;
      while (n < 200 && bus.nv_save_req !== 1'b1) begin idle(1); n++; end
      checkOutput("save_delay", n, S);
      nv_access(16'h0401, 0, 1);
      checkOutput("ack_drop", bus.nv_save_req, 0);
      n = 0;
      while (n < 200 && bus.nv_save_req !== 1'b1) begin idle(1); n++; end
      checkOutput("save_redelay", n, S);
      idle(1, 1);
      idle(S + 20);
      checkOutput("saved_clean", bus.nv_save_req, 0);
`else
      n = 0;
      for (int k = 0; k < S + 20; k++) idle(1, k[0]);
      checkOutput("no_autosave", bus.nv_save_req, 0);
`endif

      // randomized traffic against the model
      for (int it = 0; it < 2500; it++) begin
         int sel = $urandom_range(99);
         int r   = $urandom_range(19);
         int pg  = $urandom_range(3) * 256;
         if (sel < 2) begin
            reset_n = 0;
            idle(1);
            reset_n = 1;
         end else if (sel < 4) begin
            cur_active = ~cur_active;
            idle(1);
         end else if (sel < 34) begin
            win_access($urandom_range(3), $urandom_range(8191), $urandom_range(1));
         end else if (sel < 54) begin
            if (r < 16) reg_write(pg + r % 8, 8'($urandom));
            else if (r < 18) reg_write(pg + 8'h80, 8'($urandom));
            else if (r == 18) reg_write(pg + 8'h81, 8'($urandom));
            else reg_write(pg + $urandom_range(8, 127), 8'($urandom));
         end else if (sel < 70) begin
            if (r < 16) reg_read(pg + r % 8);
            else if (r < 18) reg_read(pg + 8'h80);
            else if (r == 18) reg_read(pg + 8'h81);
            else reg_read(pg + $urandom_range(8, 127));
         end else if (sel < 85) begin
            if (r < 10) nv_access(16'(16'h0400 + $urandom_range(16'h0BFF)),
                                  $urandom_range(1), r < 2);
            else nv_access(16'(16'h9800 + $urandom_range(16'h03FF)),
                           $urandom_range(1), r < 12);
         end else begin
            idle(1, r < 5);
         end
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
